// File: rtl/parking_lane_detector.sv
// parking_lane_detector: per-lane debounced beam sensors and entry/exit FSMs feeding a shared saturating occupancy counter
module parking_lane_detector #(
    parameter  int LANES    = 4,
    parameter  int DEBOUNCE = 4,
    parameter  int CAPACITY = 200,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] sd_a,
    input  logic [LANES-1:0] sd_b,
    input  logic             clr_err,
    output logic [LANES-1:0] inc,
    output logic [LANES-1:0] dec,
    output logic [LANES-1:0] abort,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);
    localparam int NS = 2 * LANES;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int AW = CNT_W + $clog2(LANES) + 2;
    localparam logic signed [AW-1:0] CAP_S = AW'(CAPACITY);

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT} state_t;

    logic [NS-1:0] s1_q, s1_d, s2_q, s2_d, f_q, f_d;
    logic [NS-1:0][DW-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] a, b;
    state_t st_q [LANES];
    state_t st_d [LANES];
    logic [LANES-1:0] inc_q, inc_d, dec_q, dec_d, abort_q, abort_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic signed [AW-1:0] sum;

    always_comb begin
        s1_d  = {sd_b, sd_a};
        s2_d  = s1_q;
        f_d   = f_q;
        cnt_d = '0;
        for (int i = 0; i < NS; i++) begin
            if (s2_q[i] != f_q[i]) begin
                cnt_d[i] = cnt_q[i] + DW'(1);
                if (cnt_d[i] == DW'(DEBOUNCE)) begin
                    cnt_d[i] = '0;
                    f_d[i]   = s2_q[i];
                end
            end
        end
    end

    assign a = ~f_q[LANES-1:0];
    assign b = ~f_q[NS-1:LANES];

    always_comb begin
        inc_d   = '0;
        dec_d   = '0;
        abort_d = '0;
        for (int i = 0; i < LANES; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                IDLE: case ({a[i], b[i]})
                    2'b10:   st_d[i] = EN1;
                    2'b01:   st_d[i] = EX1;
                    2'b11:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EN1: case ({a[i], b[i]})
                    2'b11:   st_d[i] = EN2;
                    2'b00:   st_d[i] = IDLE;
                    2'b01:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EN2: case ({a[i], b[i]})
                    2'b01:   st_d[i] = EN3;
                    2'b10:   st_d[i] = EN1;
                    2'b00:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EN3: case ({a[i], b[i]})
                    2'b00:   begin st_d[i] = IDLE; inc_d[i] = 1'b1; end
                    2'b11:   st_d[i] = EN2;
                    2'b10:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EX1: case ({a[i], b[i]})
                    2'b11:   st_d[i] = EX2;
                    2'b00:   st_d[i] = IDLE;
                    2'b10:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EX2: case ({a[i], b[i]})
                    2'b10:   st_d[i] = EX3;
                    2'b01:   st_d[i] = EX1;
                    2'b00:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                EX3: case ({a[i], b[i]})
                    2'b00:   begin st_d[i] = IDLE; dec_d[i] = 1'b1; end
                    2'b11:   st_d[i] = EX2;
                    2'b01:   begin st_d[i] = WAIT; abort_d[i] = 1'b1; end
                    default: ;
                endcase
                default: st_d[i] = ({a[i], b[i]} == 2'b00) ? IDLE : WAIT;
            endcase
        end
    end

    // net all lanes in wide signed arithmetic before clamping
    always_comb begin
        sum = AW'(occ_q);
        for (int i = 0; i < LANES; i++) sum = sum + AW'(inc_q[i]) - AW'(dec_q[i]);
        occ_d = (sum > CAP_S) ? CNT_W'(CAPACITY) : sum[AW-1] ? '0 : sum[CNT_W-1:0];
        ovf_d = (sum > CAP_S) | (ovf_q & ~clr_err);
        unf_d = sum[AW-1] | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '1;
            s2_q    <= '1;
            f_q     <= '1;
            cnt_q   <= '0;
            for (int i = 0; i < LANES; i++) st_q[i] <= IDLE;
            inc_q   <= '0;
            dec_q   <= '0;
            abort_q <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < LANES; i++) st_q[i] <= st_d[i];
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            abort_q <= abort_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign inc       = inc_q;
    assign dec       = dec_q;
    assign abort     = abort_q;
    assign occupancy = occ_q;
    assign full      = occ_q == CNT_W'(CAPACITY);
    assign empty     = occ_q == '0;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
endmodule

// File: doc/parking_lane_detector.md
# parking_lane_detector

Multi-lane, parametrised successor to the single-entrance car detector. It serves LANES independent gates, each with an outer (A) and inner (B) active-low break-beam sensor pair. Each lane synchronises and debounces its sensors and classifies full entry/exit sequences with a per-lane FSM. A shared saturating occupancy counter with full/empty flags and sticky error flags sits above the lanes.

## Interface
- LANES, 4: number of gates, 1..16
- DEBOUNCE, 4: consecutive synchronised samples required to accept a sensor change, 1..255
- CAPACITY, 200: maximum occupancy, 1..65535
- CNT_W, $clog2(CAPACITY+1): occupancy width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sd_a  in  LANES  outer sensors, 0 = beam blocked, asynchronous
- sd_b  in  LANES  inner sensors, 0 = beam blocked, asynchronous
- clr_err  in  1  synchronous clear of ovf_err/unf_err
- inc  out  LANES  one-cycle pulse per completed entry
- dec  out  LANES  one-cycle pulse per completed exit
- abort  out  LANES  one-cycle pulse per illegal sequence
- occupancy  out  CNT_W  current car count
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0
- ovf_err  out  1  sticky: an increment was lost at CAPACITY
- unf_err  out  1  sticky: a decrement was lost at 0

## Operation
- Reset, async assert: inc/dec/abort = 0, occupancy = 0, empty = 1, full = 0, both error flags = 0, all FSMs in IDLE.
- Reset also sets the synchroniser and filtered sensor values to "unblocked" and clears the debounce counters.
- Per-sensor front end: 2-flop synchroniser feeds a debounce counter.
  - Counter increments while the synced value differs from the filtered value and clears when they match.
  - Filtered value takes the synced value on the edge where the counter would reach DEBOUNCE.
  - Pulses shorter than DEBOUNCE samples are ignored.
- Per-lane FSM input is the filtered blocked pair {a,b}; 1 = blocked.
  - IDLE: 10→EN1; 01→EX1; 11→WAIT with abort; 00 stay.
  - EN1: 11→EN2; 00→IDLE (back-out, no pulse); 01→WAIT with abort.
  - EN2: 01→EN3; 10→EN1; 00→WAIT with abort.
  - EN3: 00→IDLE with inc; 11→EN2; 10→WAIT with abort.
  - EX1/EX2/EX3 mirror EN1/EN2/EN3 with a and b swapped; EX3→IDLE on 00 with dec.
  - WAIT: stay until 00, then →IDLE; no pulses while in WAIT.
- Occupancy: each cycle, next = occupancy + popcount(inc) − popcount(dec), clamped to [0, CAPACITY].
  - Internal arithmetic is signed, CNT_W+$clog2(LANES)+2 bits, so simultaneous multi-lane events never wrap.
  - Clamp at top sets ovf_err; clamp at bottom sets unf_err.
  - Simultaneous inc and dec net out before clamping; an error is flagged only if the net result is out of range.
- clr_err clears both flags. If a new clamp happens in the same cycle, set wins over clear.
- full and empty decode the registered occupancy.
- inc/dec pulses are always issued, even when the count clamps.

## Timing
- Sensor change sampled at edge k: synced value at k+1, filtered value at k+1+DEBOUNCE.
- FSM state and inc/dec/abort registered at k+2+DEBOUNCE; occupancy/full/empty at k+3+DEBOUNCE.
- With DEBOUNCE=4, inc rises 6 edges after the edge sampling the final beam clear, and occupancy updates on the 7th edge.
- Reset mid-sequence discards the partial sequence; no pulse is issued after reset release.
- After reset release, sensors held blocked are accepted through normal debounce, so they enter the FSM as fresh transitions.
- Lanes are fully independent; all LANES may complete on the same edge.

## Test plan
- Entry, lane 0, DEBOUNCE=4, 4-cycle phases (A low, B low, A high, B high): one inc[0] pulse 6 cycles after B rises; occupancy 0→1; empty falls.
- Exit, lane 2, reverse order from occupancy 1: dec[2] pulse; occupancy 1→0; empty=1; unf_err stays 0.
- Glitches: 3-cycle low pulse on sd_a[1] → no FSM activity. Back-out (A low, then A high) → no pulse. A and B both low on the same edge from IDLE → abort[1], then WAIT until both clear.
- All 4 lanes complete an entry on the same cycle at occupancy CAPACITY−2 → occupancy=CAPACITY, full=1, ovf_err=1. Assert clr_err → ovf_err=0.
- Same-cycle inc on lane 0 and dec on lane 3 at occupancy 0 → occupancy stays 0, unf_err=0.
- Assert rst_n low while lane 0 is in EN2 → all outputs at reset values. Release with sensors high → no pulse; a subsequent full entry counts normally.
